// File: rtl/fir_filter_param.sv
// Sequential multiply-accumulate FIR: one tap per cycle, one output per TAPS+2 cycles.
// Define FIR_FILTER_SATURATE_EN to clamp the scaled output instead of wrapping it.
module fir_filter_param #(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned COEF_W    = 20,
    parameter int unsigned TAPS      = 16,
    parameter int unsigned OUT_SHIFT = COEF_W - 1
) (
    input  logic                                     clk_fast,
    input  logic                                     resetn,
    input  logic signed [DATA_W-1:0]                 din,
    input  logic                                     valid_in,
    output logic                                     ready_in,
    input  logic signed [COEF_W-1:0]                 CIN,
    input  logic [((TAPS > 1) ? $clog2(TAPS) : 1)-1:0] CADDR,
    input  logic                                     CLOAD,
    output logic signed [DATA_W-1:0]                 dout,
    output logic                                     valid_out,
    output logic                                     drop
);

    localparam int unsigned ADDR_W = (TAPS > 1) ? $clog2(TAPS) : 1;
    localparam int unsigned PROD_W = DATA_W + COEF_W;
    localparam int unsigned ACC_W  = DATA_W + COEF_W + $clog2(TAPS);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(TAPS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        OUT  = 2'd2
    } state_t;

    state_t                     r_state;
    state_t                     w_next_state;
    logic                       w_accept;
    logic                       w_mac;
    logic                       w_out;
    logic                       w_drop;

    logic signed [DATA_W-1:0]   r_x    [TAPS];
    logic signed [COEF_W-1:0]   r_coef [TAPS];
    logic signed [ACC_W-1:0]    r_acc;
    logic [ADDR_W-1:0]          r_idx;
    logic signed [DATA_W-1:0]   r_dout;
    logic                       r_valid_out;
    logic                       r_drop;
    logic                       r_ready_in;

    logic signed [PROD_W-1:0]   w_prod;
    logic signed [ACC_W-1:0]    w_prod_ext;
    logic signed [DATA_W-1:0]   w_result;
    logic                       w_coef_we;

    // State register
    always_ff @(posedge clk_fast) begin
        if (!resetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and per-cycle control
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_mac        = 1'b0;
        w_out        = 1'b0;
        w_drop       = 1'b0;
        case (r_state)
            IDLE: begin
                if (valid_in) begin
                    w_accept     = 1'b1;
                    w_next_state = MAC;
                end
            end
            MAC: begin
                w_mac  = 1'b1;
                w_drop = valid_in;
                if (r_idx == LAST_IDX) begin
                    w_next_state = OUT;
                end
            end
            OUT: begin
                w_out        = 1'b1;
                w_drop       = valid_in;
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    assign w_prod     = r_x[r_idx] * r_coef[r_idx];
    assign w_prod_ext = ACC_W'(w_prod);

`ifdef FIR_FILTER_SATURATE_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
    logic signed [ACC_W-1:0] w_shifted;

    assign w_shifted = r_acc >>> OUT_SHIFT;

    // Clamp to the representable output range
    always_comb begin
        if (w_shifted > SAT_MAX) begin
            w_result = DATA_W'(SAT_MAX);
        end else if (w_shifted < SAT_MIN) begin
            w_result = DATA_W'(SAT_MIN);
        end else begin
            w_result = w_shifted[DATA_W-1:0];
        end
    end
`else
    assign w_result = DATA_W'(r_acc >>> OUT_SHIFT);
`endif

    // Delay line, accumulator and output registers
    always_ff @(posedge clk_fast) begin
        if (!resetn) begin
            for (int k = 0; k < int'(TAPS); k++) begin
                r_x[k] <= '0;
            end
            r_acc       <= '0;
            r_idx       <= '0;
            r_dout      <= '0;
            r_valid_out <= 1'b0;
            r_drop      <= 1'b0;
            r_ready_in  <= 1'b1;
        end else begin
            r_valid_out <= w_out;
            r_drop      <= w_drop;
            r_ready_in  <= (w_next_state == IDLE);
            if (w_accept) begin
                for (int k = int'(TAPS) - 1; k > 0; k--) begin
                    r_x[k] <= r_x[k-1];
                end
                r_x[0] <= din;
                r_acc  <= '0;
                r_idx  <= '0;
            end
            if (w_mac) begin
                r_acc <= r_acc + w_prod_ext;
                r_idx <= (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;
            end
            if (w_out) begin
                r_dout <= w_result;
            end
        end
    end

    // Coefficient bank survives reset and may be written while reset is held
    assign w_coef_we = CLOAD && (r_state == IDLE || !resetn) && (32'(CADDR) < TAPS);

    always_ff @(posedge clk_fast) begin
        if (w_coef_we) begin
            r_coef[CADDR] <= CIN;
        end
    end

    assign ready_in  = r_ready_in;
    assign dout      = r_dout;
    assign valid_out = r_valid_out;
    assign drop      = r_drop;

endmodule
